mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single memory bus (read/write strobes, 3-bit size option, 32-bit address/data, response pulse) between two requesters: master 0 (core) and master 1 (DMA/debug).
- Latches the winning request into registers and drives the slave from those registers. Returns read data and a one-cycle response to the granted master. A watchdog aborts slave transactions that never respond.

Parameters:
- RR_ENABLE, 1, 1 = round-robin between the masters; 0 = fixed priority with master 0 winning.
- TIMEOUT, 255, number of BUSY cycles without s_response before the transaction is aborted; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m0_read, m0_write  in  1 each  master 0 request strobes; level, held until m0_response
- m0_option  in  3  master 0 access size/sign code; passed through unchanged
- m0_address  in  32  master 0 address
- m0_write_data  in  32  master 0 store data
- m0_read_data  out  32  master 0 load data; valid while m0_response is high, then held
- m0_response  out  1  one-cycle completion pulse to master 0
- m0_error  out  1  high together with m0_response when the transaction timed out
- m1_*  same set as m0_*, for master 1
- s_read, s_write  out  1 each  slave strobes; level, high for the whole BUSY state
- s_option  out  3  latched option
- s_address  out  32  latched address
- s_write_data  out  32  latched store data
- s_read_data  in  32  slave load data; valid when s_response is high
- s_response  in  1  slave completion pulse
- grant  out  2  one-hot owner of the bus; 00 when idle
- busy  out  1  high in BUSY and DONE

Behaviour:
- Definitions:
  - reqN = mN_read | mN_write.
  - If a master asserts both read and write, write takes precedence: s_write=1, s_read=0.
- Reset:
  - All outputs go to 0 and the state goes to IDLE.
  - last_grant is set to 1, so master 0 wins the first tie.
  - The watchdog counter is cleared.
  - Reset asserted mid-transaction drops the slave strobes in the following cycle, and no response pulse is generated.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: stays in IDLE.
- IDLE, one request: that master wins.
- IDLE, both requesting:
  - With RR_ENABLE=1 the master != last_grant wins.
  - With RR_ENABLE=0 master 0 wins.
- IDLE, on a win:
  - Latch the winner's option, address, write_data, read and write into the s_* registers.
  - Set grant and last_grant.
  - Clear the counter.
  - Go to BUSY.
  - The slave strobes rise exactly 1 cycle after the request is first sampled.
- BUSY:
  - s_* outputs stay constant and master inputs are ignored.
  - The counter increments each cycle.
- BUSY, on s_response=1:
  - Latch s_read_data into the granted master's read_data register.
  - Drop the strobes next cycle.
  - Go to DONE.
- BUSY, on timeout (TIMEOUT!=0, counter reaches TIMEOUT-1 with no s_response):
  - Latch read_data=0 and set the error flag.
  - Drop the strobes.
  - Go to DONE.
  - The timeout check and s_response are evaluated in the same cycle; s_response has priority over timeout.
- DONE (exactly 1 cycle):
  - mN_response=1 for the granted master only, with mN_error as latched.
  - No arbitration takes place.
  - grant is cleared on exit and the state returns to IDLE.
- After DONE:
  - A request still high in the cycle after the response is treated as a new transaction.
  - Minimum turnaround: strobes low for 2 cycles (DONE, IDLE) between back-to-back transactions.
- Read data:
  - The non-granted master's read_data is unchanged.
  - mN_read_data holds its last value until that master's next completion.
  - A write completion also latches s_read_data; masters ignore it.
- s_response arriving in IDLE or DONE is ignored.
- Response latency: mN_response is 1 cycle after s_response.

Test Plan:
- Single read: m0 read at addr 0x100, option 3'b010; slave responds 3 cycles after the strobe with 0xCAFEBABE -> s_read 1 cycle after request, m0_response pulse 1 cycle after s_response, m0_read_data=0xCAFEBABE, m0_error=0.
- Simultaneous requests: m0 and m1 assert together after reset, RR_ENABLE=1, both held -> order m0, m1, m0, m1 with grants 01/10 alternating; with RR_ENABLE=0 -> m0 served every time and m1 starves while m0 holds its request.
- Write during contention: m1 write 0x12345678 to 0x2000 while m0 is in BUSY -> m0 completes first; s_write_data=0x12345678 and s_address=0x2000 are stable through m1's BUSY.
- Timeout: TIMEOUT=8, slave never responds -> strobes drop after 8 BUSY cycles; m0_response=1, m0_error=1, m0_read_data=0.
- Response/timeout collision: s_response arrives in the final counting cycle -> normal completion, error=0, slave data returned.
- Reset mid-BUSY: assert reset during m1's transaction -> next cycle all outputs 0, no m1_response; a subsequent m1 request is served normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of every bus signal around the two-master memory arbiter:
// the two requester links (m0_*, m1_*), the shared slave link (s_*),
// and the arbiter status outputs.
// The "slave" modport is the arbiter's own view: it serves the masters.
// The "master" modport is the environment's view: the masters and the memory.
interface mem_bus_arbiter_if;
    logic        m0_read;
    logic        m0_write;
    logic [2:0]  m0_option;
    logic [31:0] m0_address;
    logic [31:0] m0_write_data;
    logic [31:0] m0_read_data;
    logic        m0_response;
    logic        m0_error;

    logic        m1_read;
    logic        m1_write;
    logic [2:0]  m1_option;
    logic [31:0] m1_address;
    logic [31:0] m1_write_data;
    logic [31:0] m1_read_data;
    logic        m1_response;
    logic        m1_error;

    logic        s_read;
    logic        s_write;
    logic [2:0]  s_option;
    logic [31:0] s_address;
    logic [31:0] s_write_data;
    logic [31:0] s_read_data;
    logic        s_response;

    logic [1:0]  grant;
    logic        busy;

    modport slave (
        input  m0_read, m0_write, m0_option, m0_address, m0_write_data,
        output m0_read_data, m0_response, m0_error,
        input  m1_read, m1_write, m1_option, m1_address, m1_write_data,
        output m1_read_data, m1_response, m1_error,
        output s_read, s_write, s_option, s_address, s_write_data,
        input  s_read_data, s_response,
        output grant, busy
    );

    modport master (
        output m0_read, m0_write, m0_option, m0_address, m0_write_data,
        input  m0_read_data, m0_response, m0_error,
        output m1_read, m1_write, m1_option, m1_address, m1_write_data,
        input  m1_read_data, m1_response, m1_error,
        input  s_read, s_write, s_option, s_address, s_write_data,
        output s_read_data, s_response,
        input  grant, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter. The winning request is captured into
// registers that drive the slave for the whole transaction. The completion
// (or a watchdog abort) is returned to the granted master as a one-cycle
// response pulse one cycle later.
module mem_bus_arbiter #(
    parameter int RR_ENABLE = 1,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave io_bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] LP_LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_s_read;
    logic        r_s_write;
    logic [2:0]  r_s_option;
    logic [31:0] r_s_address;
    logic [31:0] r_s_write_data;
    logic [31:0] r_m0_read_data;
    logic [31:0] r_m1_read_data;
    logic        r_m0_response;
    logic        r_m1_response;
    logic        r_error;
    logic [1:0]  r_grant;
    logic        r_last_grant;
    logic [CNT_W-1:0] r_cnt;

    logic        w_req0;
    logic        w_req1;
    logic        w_win;
    logic        w_pick1;
    logic        w_timeout;

    // Decode requests and pick a winner; on a tie, round-robin prefers whoever did not win last.
    always_comb begin
        w_req0    = io_bus.m0_read | io_bus.m0_write;
        w_req1    = io_bus.m1_read | io_bus.m1_write;
        w_win     = w_req0 | w_req1;
        w_pick1   = w_req1 & (~w_req0 | ((RR_ENABLE != 0) & ~r_last_grant));
        w_timeout = (TIMEOUT != 0) && (r_cnt == LP_LAST_CNT);
    end

    // Next-state logic: a response takes priority over the watchdog, and DONE always lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_win) w_state_next = BUSY;
            BUSY:    if (io_bus.s_response || w_timeout) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Datapath: capture the winner, count busy cycles, and collect the completion for the owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_read       <= 1'b0;
            r_s_write      <= 1'b0;
            r_s_option     <= '0;
            r_s_address    <= '0;
            r_s_write_data <= '0;
            r_m0_read_data <= '0;
            r_m1_read_data <= '0;
            r_m0_response  <= 1'b0;
            r_m1_response  <= 1'b0;
            r_error        <= 1'b0;
            r_grant        <= 2'b00;
            r_last_grant   <= 1'b1;
            r_cnt          <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_win) begin
                        if (w_pick1) begin
                            r_s_read       <= io_bus.m1_read & ~io_bus.m1_write;
                            r_s_write      <= io_bus.m1_write;
                            r_s_option     <= io_bus.m1_option;
                            r_s_address    <= io_bus.m1_address;
                            r_s_write_data <= io_bus.m1_write_data;
                            r_grant        <= 2'b10;
                        end else begin
                            r_s_read       <= io_bus.m0_read & ~io_bus.m0_write;
                            r_s_write      <= io_bus.m0_write;
                            r_s_option     <= io_bus.m0_option;
                            r_s_address    <= io_bus.m0_address;
                            r_s_write_data <= io_bus.m0_write_data;
                            r_grant        <= 2'b01;
                        end
                        r_last_grant <= w_pick1;
                        r_cnt        <= '0;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (io_bus.s_response || w_timeout) begin
                        r_s_read      <= 1'b0;
                        r_s_write     <= 1'b0;
                        r_error       <= ~io_bus.s_response;
                        r_m0_response <= r_grant[0];
                        r_m1_response <= r_grant[1];
                        if (r_grant[1])
                            r_m1_read_data <= io_bus.s_response ? io_bus.s_read_data : 32'h0;
                        else
                            r_m0_read_data <= io_bus.s_response ? io_bus.s_read_data : 32'h0;
                    end
                end
                DONE: begin
                    r_m0_response <= 1'b0;
                    r_m1_response <= 1'b0;
                    r_error       <= 1'b0;
                    r_grant       <= 2'b00;
                end
                default: begin
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign io_bus.s_read        = r_s_read;
    assign io_bus.s_write       = r_s_write;
    assign io_bus.s_option      = r_s_option;
    assign io_bus.s_address     = r_s_address;
    assign io_bus.s_write_data  = r_s_write_data;
    assign io_bus.m0_read_data  = r_m0_read_data;
    assign io_bus.m1_read_data  = r_m1_read_data;
    assign io_bus.m0_response   = r_m0_response;
    assign io_bus.m1_response   = r_m1_response;
    assign io_bus.m0_error      = r_m0_response & r_error;
    assign io_bus.m1_error      = r_m1_response & r_error;
    assign io_bus.grant         = r_grant;
    assign io_bus.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter. A transaction-level model keeps the pending
// request of each master, the last winner and each master's last read data;
// every transaction is checked at strobe start, through BUSY, in DONE and in
// the following IDLE cycle.
module tb_mem_bus_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    bit          pend  [2];
    bit          prd   [2];
    bit          pwr   [2];
    logic [2:0]  popt  [2];
    logic [31:0] paddr [2];
    logic [31:0] pdat  [2];
    logic [31:0] mdata [2];
    int          lastWin;

    bit          lateRd;
    bit          lateWr;
    logic [2:0]  lateOpt;
    logic [31:0] lateAddr;
    logic [31:0] lateData;

    mem_bus_arbiter_if bus();
    mem_bus_arbiter_if fpBus();

    mem_bus_arbiter #(.RR_ENABLE(1), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    mem_bus_arbiter #(.RR_ENABLE(0), .TIMEOUT(TO), .CNT_W(8)) dutFp (
        .clk    (clk),
        .reset  (reset),
        .io_bus (fpBus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the run never reaches its summary.
    initial begin
        #2000000;
        $display("[TB] FAIL sim_time_limit observed=expired required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic getResp(input int m);
        return (m == 0) ? bus.m0_response : bus.m1_response;
    endfunction

    function automatic logic getErr(input int m);
        return (m == 0) ? bus.m0_error : bus.m1_error;
    endfunction

    function automatic logic [31:0] getData(input int m);
        return (m == 0) ? bus.m0_read_data : bus.m1_read_data;
    endfunction

    task automatic driveMaster(input int m);
        if (m == 0) begin
            bus.m0_read       = pend[0] & prd[0];
            bus.m0_write      = pend[0] & pwr[0];
            bus.m0_option     = popt[0];
            bus.m0_address    = paddr[0];
            bus.m0_write_data = pdat[0];
        end else begin
            bus.m1_read       = pend[1] & prd[1];
            bus.m1_write      = pend[1] & pwr[1];
            bus.m1_option     = popt[1];
            bus.m1_address    = paddr[1];
            bus.m1_write_data = pdat[1];
        end
    endtask

    task automatic applyStimulus(input int m, input bit rd, input bit wr, input logic [2:0] opt,
                                 input logic [31:0] addr, input logic [31:0] data);
        pend[m]  = 1'b1;
        prd[m]   = rd;
        pwr[m]   = wr;
        popt[m]  = opt;
        paddr[m] = addr;
        pdat[m]  = data;
        driveMaster(m);
    endtask

    task automatic newRandomRequest(input int m);
        int kind;
        kind = int'($urandom_range(0, 2));
        applyStimulus(m, kind != 1, kind != 0, 3'($urandom), $urandom, $urandom);
    endtask

    task automatic setLate(input bit rd, input bit wr, input logic [2:0] opt,
                           input logic [31:0] addr, input logic [31:0] data);
        lateRd   = rd;
        lateWr   = wr;
        lateOpt  = opt;
        lateAddr = addr;
        lateData = data;
    endtask

    // One arbitration plus transaction, starting in an IDLE cycle with requests already driven.
    // lat = BUSY cycle (0-based) in which the slave responds; lat >= TO means it never responds.
    task automatic serveOne(input int lat, input logic [31:0] rdata, input bit late);
        int w;
        int o;
        bit timedOut;
        if (pend[0] && pend[1]) w = (lastWin == 0) ? 1 : 0;
        else if (pend[1])       w = 1;
        else                    w = 0;
        o = 1 - w;
        lastWin = w;

        tick();
        checkOutput("start_s_read",  32'(bus.s_read),  32'(prd[w] & ~pwr[w]));
        checkOutput("start_s_write", 32'(bus.s_write), 32'(pwr[w]));
        checkOutput("start_s_address", bus.s_address, paddr[w]);
        checkOutput("start_s_option", 32'(bus.s_option), 32'(popt[w]));
        checkOutput("start_s_wdata", bus.s_write_data, pdat[w]);
        checkOutput("start_grant", 32'(bus.grant), (w == 1) ? 32'h2 : 32'h1);
        checkOutput("start_busy", 32'(bus.busy), 32'h1);

        for (int k = 0; k < TO; k++) begin
            if (k > 0) begin
                checkOutput("busy_strobe", 32'(bus.s_read | bus.s_write), 32'h1);
                checkOutput("busy_s_address", bus.s_address, paddr[w]);
                checkOutput("busy_s_wdata", bus.s_write_data, pdat[w]);
            end
            if (k == lat) begin
                bus.s_response  = 1'b1;
                bus.s_read_data = rdata;
            end
            if (k == 1 && late && !pend[o])
                applyStimulus(o, lateRd, lateWr, lateOpt, lateAddr, lateData);
            tick();
            bus.s_response  = 1'b0;
            bus.s_read_data = $urandom;
            if (k == lat) break;
        end

        timedOut = (lat >= TO);
        mdata[w] = timedOut ? 32'h0 : rdata;
        checkOutput("done_resp_owner", 32'(getResp(w)), 32'h1);
        checkOutput("done_resp_other", 32'(getResp(o)), 32'h0);
        checkOutput("done_err_owner", 32'(getErr(w)), 32'(timedOut));
        checkOutput("done_err_other", 32'(getErr(o)), 32'h0);
        checkOutput("done_rdata_owner", getData(w), mdata[w]);
        checkOutput("done_rdata_other", getData(o), mdata[o]);
        checkOutput("done_strobes", 32'({bus.s_read, bus.s_write}), 32'h0);
        checkOutput("done_busy", 32'(bus.busy), 32'h1);

        pend[w] = 1'b0;
        driveMaster(w);
        tick();
        checkOutput("idle_resp", 32'({bus.m0_response, bus.m1_response}), 32'h0);
        checkOutput("idle_busy", 32'(bus.busy), 32'h0);
        checkOutput("idle_grant", 32'(bus.grant), 32'h0);
        checkOutput("idle_strobes", 32'({bus.s_read, bus.s_write}), 32'h0);
        checkOutput("idle_rdata0", bus.m0_read_data, mdata[0]);
        checkOutput("idle_rdata1", bus.m1_read_data, mdata[1]);
    endtask

    // Directed scenarios followed by randomized traffic, all in one linear sequence.
    initial begin
        int m0Count;
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; prd[m] = 1'b0; pwr[m] = 1'b0;
            popt[m] = '0; paddr[m] = '0; pdat[m] = '0; mdata[m] = '0;
            driveMaster(m);
        end
        lastWin = 1;
        setLate(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.s_response = 1'b0;
        bus.s_read_data = '0;
        fpBus.m0_read = 1'b0; fpBus.m0_write = 1'b0; fpBus.m0_option = '0;
        fpBus.m0_address = '0; fpBus.m0_write_data = '0;
        fpBus.m1_read = 1'b0; fpBus.m1_write = 1'b0; fpBus.m1_option = '0;
        fpBus.m1_address = '0; fpBus.m1_write_data = '0;
        fpBus.s_response = 1'b0; fpBus.s_read_data = '0;

        tick();
        tick();
        checkOutput("rst_strobes", 32'({bus.s_read, bus.s_write}), 32'h0);
        checkOutput("rst_grant", 32'(bus.grant), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_resp", 32'({bus.m0_response, bus.m1_response, bus.m0_error, bus.m1_error}), 32'h0);
        checkOutput("rst_rdata0", bus.m0_read_data, 32'h0);
        checkOutput("rst_rdata1", bus.m1_read_data, 32'h0);
        checkOutput("rst_s_address", bus.s_address, 32'h0);
        reset = 1'b0;
        tick();

        // Both masters hold requests from reset: alternation m0, m1, m0, m1, m0.
        applyStimulus(0, 1'b1, 1'b0, 3'b000, 32'h0000_0010, 32'h0);
        applyStimulus(1, 1'b0, 1'b1, 3'b001, 32'h0000_0020, 32'hAAAA_0001);
        serveOne(1, 32'h1111_1111, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 3'b000, 32'h0000_0014, 32'h0);
        serveOne(0, 32'h2222_2222, 1'b0);
        applyStimulus(1, 1'b1, 1'b1, 3'b011, 32'h0000_0024, 32'hAAAA_0002);
        serveOne(2, 32'h3333_3333, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 3'b100, 32'h0000_0018, 32'hBBBB_0003);
        serveOne(1, 32'h4444_4444, 1'b0);
        serveOne(3, 32'h5555_5555, 1'b0);

        // Single read with the slave answering three cycles into BUSY.
        applyStimulus(0, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        serveOne(3, 32'hCAFE_BABE, 1'b0);

        // m1 write arrives while m0 is busy; m0 completes first, then m1 with stable fields.
        applyStimulus(0, 1'b1, 1'b0, 3'b000, 32'h0000_0300, 32'h0);
        setLate(1'b0, 1'b1, 3'b010, 32'h0000_2000, 32'h1234_5678);
        serveOne(2, 32'h0BAD_F00D, 1'b1);
        serveOne(4, 32'h7777_7777, 1'b0);

        // Watchdog abort, then a response in the last counting cycle.
        applyStimulus(0, 1'b1, 1'b0, 3'b001, 32'h0000_0400, 32'h0);
        serveOne(99, 32'hDEAD_DEAD, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 3'b001, 32'h0000_0404, 32'h0);
        serveOne(TO - 1, 32'hA5A5_5A5A, 1'b0);

        // Reset in the middle of an m1 transaction.
        applyStimulus(1, 1'b1, 1'b0, 3'b001, 32'h0000_4000, 32'h0);
        tick();
        checkOutput("rstmid_busy", 32'(bus.busy), 32'h1);
        tick();
        reset = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        driveMaster(0);
        driveMaster(1);
        tick();
        checkOutput("rstmid_strobes", 32'({bus.s_read, bus.s_write}), 32'h0);
        checkOutput("rstmid_grant", 32'(bus.grant), 32'h0);
        checkOutput("rstmid_busy_low", 32'(bus.busy), 32'h0);
        checkOutput("rstmid_m1_resp", 32'(bus.m1_response), 32'h0);
        checkOutput("rstmid_rdata0", bus.m0_read_data, 32'h0);
        checkOutput("rstmid_rdata1", bus.m1_read_data, 32'h0);
        mdata[0] = '0;
        mdata[1] = '0;
        lastWin = 1;
        tick();
        checkOutput("rstmid_m1_resp_hold", 32'(bus.m1_response), 32'h0);
        reset = 1'b0;
        tick();
        applyStimulus(1, 1'b1, 1'b0, 3'b001, 32'h0000_4000, 32'h0);
        serveOne(2, 32'h5555_AAAA, 1'b0);

        // Randomized traffic: random requesters, kinds, late arrivals and slave latencies.
        for (int it = 0; it < 40; it++) begin
            for (int m = 0; m < 2; m++)
                if (!pend[m] && ($urandom_range(0, 1) == 1)) newRandomRequest(m);
            if (!pend[0] && !pend[1]) newRandomRequest(int'($urandom_range(0, 1)));
            setLate(1'($urandom_range(0, 1)), 1'b1, 3'($urandom), $urandom, $urandom);
            serveOne(int'($urandom_range(0, 10)), $urandom, 1'($urandom_range(0, 1)));
        end
        for (int d = 0; d < 2; d++)
            if (pend[0] || pend[1]) serveOne(1, $urandom, 1'b0);

        // Fixed priority: both hold requests, m0 must win every time.
        fpBus.m0_read = 1'b1;
        fpBus.m0_address = 32'h0000_0050;
        fpBus.m1_write = 1'b1;
        fpBus.m1_address = 32'h0000_0060;
        fpBus.m1_write_data = 32'hFEED_0001;
        m0Count = 0;
        for (int c = 0; c < 30; c++) begin
            fpBus.s_response  = fpBus.s_read | fpBus.s_write;
            fpBus.s_read_data = 32'(c);
            tick();
            checkOutput("fp_no_m1_grant", 32'(fpBus.grant[1]), 32'h0);
            checkOutput("fp_no_m1_resp", 32'(fpBus.m1_response), 32'h0);
            if (fpBus.m0_response) m0Count++;
        end
        fpBus.s_response = 1'b0;
        checkOutput("fp_m0_served", 32'(m0Count >= 3), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
